// File: rtl/rope_pkg.sv
// Shared constants and FSM encoding for the RoPE coefficient loader.
package rope_pkg;
   localparam int BW_FP         = 17;
   localparam int N             = 8;
   localparam int VALUE_MN      = 64;
   localparam int WORDS_PER_VEC = VALUE_MN / N;
   localparam int WORDS_PER_POS = 2 * WORDS_PER_VEC;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_LAUNCH,
      S_WAIT_HI,
      S_WAIT_LO
   } rope_ld_state_t;
endpackage

// File: rtl/rope_coef_loader_if.sv
// Request, coefficient-table and RoPE-controller signals of the loader bundled as one bus.
interface rope_coef_loader_if #(
   parameter int BW_FP    = rope_pkg::BW_FP,
   parameter int VALUE_MN = rope_pkg::VALUE_MN,
   parameter int N        = rope_pkg::N,
   parameter int POS_W    = 6,
   parameter int ADDR_W   = POS_W + 4
);
   logic                      req;
   logic [POS_W-1:0]          pos;
   logic                      decode;
   logic                      ready;
   logic                      mem_rd_en;
   logic [ADDR_W-1:0]         mem_addr;
   logic [N*BW_FP-1:0]        mem_rd_data;
   logic [VALUE_MN*BW_FP-1:0] W_cos;
   logic [VALUE_MN*BW_FP-1:0] W_sin;
   logic                      start1;
   logic                      start2;
   logic                      busy_RoPE;
   logic                      done;

   modport master (
      output req, pos, decode, mem_rd_data, busy_RoPE,
      input  ready, mem_rd_en, mem_addr, W_cos, W_sin, start1, start2, done
   );

   modport slave (
      input  req, pos, decode, mem_rd_data, busy_RoPE,
      output ready, mem_rd_en, mem_addr, W_cos, W_sin, start1, start2, done
   );
endinterface

// File: rtl/rope_coef_capture.sv
// Aligns SRAM read data with its word index and writes it into the cos/sin lane groups.
module rope_coef_capture #(
   parameter int BW_FP    = rope_pkg::BW_FP,
   parameter int VALUE_MN = rope_pkg::VALUE_MN,
   parameter int N        = rope_pkg::N
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rd_en,
   input  logic [3:0]                k,
   input  logic [N*BW_FP-1:0]        rd_data,
   output logic [VALUE_MN*BW_FP-1:0] W_cos,
   output logic [VALUE_MN*BW_FP-1:0] W_sin
);
   localparam int GW = N * BW_FP;

   logic       cap_en;
   logic [3:0] cap_k;

   // Read data lags the strobe by one cycle; words 0..7 are cos, 8..15 are sin.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_en <= 1'b0;
         cap_k  <= '0;
         W_cos  <= '0;
         W_sin  <= '0;
      end else begin
         cap_en <= rd_en;
         cap_k  <= k;
         if (cap_en) begin
            if (cap_k[3]) W_sin[int'(cap_k[2:0]) * GW +: GW] <= rd_data;
            else          W_cos[int'(cap_k[2:0]) * GW +: GW] <= rd_data;
         end
      end
   end
endmodule

// File: rtl/rope_coef_loader.sv
// Fetches one position's cos/sin rows, launches the RoPE controller and reports its completion.
module rope_coef_loader #(
   parameter int BW_FP    = rope_pkg::BW_FP,
   parameter int VALUE_MN = rope_pkg::VALUE_MN,
   parameter int N        = rope_pkg::N,
   parameter int POS_W    = 6,
   parameter int ADDR_W   = POS_W + 4
) (
   input logic               clk,
   input logic               rst,
   rope_coef_loader_if.slave bus
);
   import rope_pkg::*;

   localparam logic [3:0] K_LAST = 4'(WORDS_PER_POS - 1);

   rope_ld_state_t   state;
   logic [POS_W-1:0] pos_q;
   logic             decode_q;
   logic [3:0]       k;
   logic             done_q;
   logic             rd_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         pos_q    <= '0;
         decode_q <= 1'b0;
         k        <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               // done_q masks ready so a held request is taken only after the done pulse.
               if (bus.req && !done_q) begin
                  pos_q    <= bus.pos;
                  decode_q <= bus.decode;
                  k        <= '0;
                  state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (k == K_LAST) state <= S_DRAIN;
               else             k     <= k + 4'd1;
            end
            S_DRAIN:   state <= S_LAUNCH;
            S_LAUNCH:  if (!bus.busy_RoPE) state <= S_WAIT_HI;
            S_WAIT_HI: if (bus.busy_RoPE)  state <= S_WAIT_LO;
            S_WAIT_LO: begin
               if (!bus.busy_RoPE) begin
                  done_q <= 1'b1;
                  state  <= S_IDLE;
               end
            end
            default:   state <= S_IDLE;
         endcase
      end
   end

   assign rd_en         = (state == S_FETCH);
   assign bus.mem_rd_en = rd_en;
   assign bus.mem_addr  = ADDR_W'({pos_q, k});
   assign bus.ready     = (state == S_IDLE) && !done_q && !rst;
   assign bus.done      = done_q;
   // The only combinational input path: launch waits for an idle controller.
   assign bus.start1    = (state == S_LAUNCH) && !bus.busy_RoPE && !decode_q;
   assign bus.start2    = (state == S_LAUNCH) && !bus.busy_RoPE &&  decode_q;

   rope_coef_capture #(
      .BW_FP    (BW_FP),
      .VALUE_MN (VALUE_MN),
      .N        (N)
   ) u_capture (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (rd_en),
      .k       (k),
      .rd_data (bus.mem_rd_data),
      .W_cos   (bus.W_cos),
      .W_sin   (bus.W_sin)
   );
endmodule

// File: tb/tb_rope_coef_loader.sv
// Bench for rope_coef_loader: SRAM and RoPE controller models, table vectors, corner sequences, random loads.
module tb_rope_coef_loader;
   import rope_pkg::*;

   localparam int POS_W    = 6;
   localparam int ADDR_W   = POS_W + 4;
   localparam int GW       = N * BW_FP;
   localparam int VW       = VALUE_MN * BW_FP;
   localparam int PAT_RAMP = 0;
   localparam int PAT_HASH = 1;

   typedef struct {
      logic [POS_W-1:0]  pos;
      logic              dec;
      int                blen;
      int                hold;
      int                pat;
      logic [ADDR_W-1:0] first_addr;
      logic              s1;
      logic              s2;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          failures = 0;
   int          pat = PAT_RAMP;
   logic [31:0] seed = 32'd0;
   bit          force_busy = 1'b0;
   int          busy_len = 3;
   int          busy_cnt = 0;
   logic [VW-1:0] prev_cos = '0;
   logic [VW-1:0] prev_sin = '0;
   vec_t        tbl [5];

   rope_coef_loader_if bus ();
   rope_coef_loader dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Table contents: ramp puts the word index in every lane, hash is address-dependent and never zero.
   function automatic logic [GW-1:0] word_of(input logic [ADDR_W-1:0] a);
      logic [GW-1:0] w;
      w = '0;
      for (int j = 0; j < N; j++) begin
         if (pat == PAT_RAMP) w[j*BW_FP +: BW_FP] = BW_FP'(a[3:0]);
         else w[j*BW_FP +: BW_FP] = BW_FP'((32'(a) * 32'd2654435761) ^ 32'(j * 977) ^ seed) | BW_FP'(1);
      end
      return w;
   endfunction

   function automatic logic [VW-1:0] exp_vec(input logic [POS_W-1:0] p, input bit sin);
      logic [VW-1:0] v;
      v = '0;
      for (int g = 0; g < VALUE_MN / N; g++)
         v[g*GW +: GW] = word_of(ADDR_W'(int'(p) * 16 + (sin ? 8 : 0) + g));
      return v;
   endfunction

   always @(posedge clk)
      bus.mem_rd_data <= bus.mem_rd_en ? word_of(bus.mem_addr) : {N{17'h15A5A}};

   always @(posedge clk) begin
      if (bus.start1 || bus.start2) busy_cnt <= busy_len;
      else if (busy_cnt > 0)        busy_cnt <= busy_cnt - 1;
   end
   assign bus.busy_RoPE = force_busy || (busy_cnt != 0);

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_w(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         int l;
         l = 0;
         failures++;
         for (int i = VALUE_MN - 1; i >= 0; i--)
            if (act[i*BW_FP +: BW_FP] !== exp[i*BW_FP +: BW_FP]) l = i;
         $display("FAIL %s: lane %0d got %h expected %h", nm, l, act[l*BW_FP +: BW_FP], exp[l*BW_FP +: BW_FP]);
      end
   endtask

   // One full load: accept, 16 reads, drain, (held) launch, wait for completion.
   task automatic run_op(input vec_t v, input bit held, input logic [POS_W-1:0] hp, input logic hd);
      logic [VW-1:0] ec, es;
      int n;
      bit seen;
      pat = v.pat;
      seed = $urandom;
      busy_len = v.blen;
      ec = exp_vec(v.pos, 1'b0);
      es = exp_vec(v.pos, 1'b1);
      bus.req = 1'b1;
      bus.pos = v.pos;
      bus.decode = v.dec;
      #1 chk("ready_idle", 32'(bus.ready), 1);
      tick();
      bus.req = 1'b0;
      bus.pos = POS_W'($urandom);
      bus.decode = 1'($urandom);
      for (int i = 0; i < WORDS_PER_POS; i++) begin
         #1;
         chk("fetch_rd_en", 32'(bus.mem_rd_en), 1);
         chk("fetch_addr", 32'(bus.mem_addr), 32'(v.first_addr) + 32'(i));
         chk("fetch_quiet", 32'({bus.start1, bus.start2, bus.ready, bus.done}), 0);
         if (i == 0) begin
            chk_w("w_cos_old", bus.W_cos, prev_cos);
            chk_w("w_sin_old", bus.W_sin, prev_sin);
         end
         tick();
      end
      force_busy = (v.hold > 0);
      #1 chk("drain", 32'({bus.mem_rd_en, bus.start1, bus.start2, bus.ready}), 0);
      tick();
      for (int i = 0; i < v.hold; i++) begin
         #1;
         chk("launch_hold", 32'({bus.start1, bus.start2}), 0);
         chk_w("w_cos_hold", bus.W_cos, ec);
         tick();
         if (i == v.hold - 1) force_busy = 1'b0;
      end
      #1;
      chk("start1", 32'(bus.start1), 32'(v.s1));
      chk("start2", 32'(bus.start2), 32'(v.s2));
      chk_w("w_cos", bus.W_cos, ec);
      chk_w("w_sin", bus.W_sin, es);
      prev_cos = ec;
      prev_sin = es;
      tick();
      if (held) begin
         bus.req = 1'b1;
         bus.pos = hp;
         bus.decode = hd;
      end
      seen = 1'b0;
      n = 0;
      while (!seen && n <= v.blen + 6) begin
         #1;
         if (bus.done) seen = 1'b1;
         else begin
            chk("wait_quiet", 32'({bus.mem_rd_en, bus.ready, bus.start1, bus.start2}), 0);
            tick();
            n++;
         end
      end
      chk("done_seen", 32'(seen), 1);
      if (seen) begin
         chk("done_latency", 32'(n), 32'(v.blen + 1));
         chk("done_not_ready", 32'({bus.ready, bus.mem_rd_en}), 0);
         chk_w("w_sin_done", bus.W_sin, es);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t va, vb;
      bus.req = 1'b0;
      bus.pos = '0;
      bus.decode = 1'b0;
      tbl[0] = '{pos: 6'd5,  dec: 1'b0, blen: 3, hold: 0, pat: PAT_RAMP, first_addr: 10'd80,   s1: 1'b1, s2: 1'b0};
      tbl[1] = '{pos: 6'd63, dec: 1'b1, blen: 3, hold: 0, pat: PAT_RAMP, first_addr: 10'd1008, s1: 1'b0, s2: 1'b1};
      tbl[2] = '{pos: 6'd0,  dec: 1'b0, blen: 2, hold: 4, pat: PAT_HASH, first_addr: 10'd0,    s1: 1'b1, s2: 1'b0};
      tbl[3] = '{pos: 6'd63, dec: 1'b0, blen: 1, hold: 0, pat: PAT_HASH, first_addr: 10'd1008, s1: 1'b1, s2: 1'b0};
      tbl[4] = '{pos: 6'd17, dec: 1'b1, blen: 2, hold: 2, pat: PAT_HASH, first_addr: 10'd272,  s1: 1'b0, s2: 1'b1};

      rst = 1'b1;
      tick();
      tick();
      #1 chk("rst_ready_low", 32'(bus.ready), 0);
      tick();
      rst = 1'b0;
      #1;
      chk("rst_ready_high", 32'(bus.ready), 1);
      chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
      chk("rst_addr", 32'(bus.mem_addr), 0);
      chk("rst_pulses", 32'({bus.start1, bus.start2, bus.done}), 0);
      chk_w("rst_w_cos", bus.W_cos, '0);
      chk_w("rst_w_sin", bus.W_sin, '0);

      // Reset while word 7 is being read.
      pat = PAT_HASH;
      seed = $urandom;
      bus.req = 1'b1;
      bus.pos = 6'd9;
      bus.decode = 1'b0;
      tick();
      bus.req = 1'b0;
      repeat (7) tick();
      #1 chk("mid_addr", 32'(bus.mem_addr), 32'(9 * 16 + 7));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rd_en", 32'(bus.mem_rd_en), 0);
      chk("mid_ready", 32'(bus.ready), 1);
      chk_w("mid_w_cos", bus.W_cos, '0);
      chk_w("mid_w_sin", bus.W_sin, '0);
      tick();
      #1;
      chk_w("mid_w_cos_late", bus.W_cos, '0);
      chk("mid_rd_en_late", 32'(bus.mem_rd_en), 0);
      prev_cos = '0;
      prev_sin = '0;

      for (int i = 0; i < 5; i++) begin
         tick();
         run_op(tbl[i], 1'b0, '0, 1'b0);
         if (i == 0) begin
            chk("ramp_cos_g3", 32'(bus.W_cos[3*GW +: BW_FP]), 3);
            chk("ramp_sin_g2", 32'(bus.W_sin[2*GW +: BW_FP]), 10);
         end
      end

      // Request held through WAIT_LO with a new position.
      va = '{pos: 6'd20, dec: 1'b0, blen: 4, hold: 0, pat: PAT_RAMP, first_addr: 10'd320, s1: 1'b1, s2: 1'b0};
      vb = '{pos: 6'd33, dec: 1'b1, blen: 2, hold: 0, pat: PAT_HASH, first_addr: 10'd528, s1: 1'b0, s2: 1'b1};
      tick();
      run_op(va, 1'b1, 6'd33, 1'b1);
      tick();
      run_op(vb, 1'b0, '0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         vec_t v;
         v.pos = POS_W'($urandom);
         v.dec = 1'($urandom);
         v.blen = $urandom_range(1, 4);
         v.hold = $urandom_range(0, 2);
         v.pat = PAT_HASH;
         v.first_addr = ADDR_W'(int'(v.pos) * WORDS_PER_POS);
         v.s1 = !v.dec;
         v.s2 = v.dec;
         tick();
         run_op(v, 1'b0, '0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
